fifo_8to1_sync: RTL and testbench
=================================

Name: fifo_8to1_sync

Overview:
- Synchronous first-in-first-out buffer with an asymmetric aspect ratio: 8-bit write port, 1-bit read port.
- Each write enqueues one byte; each read dequeues one bit.
- Bits are read MSB-first within each byte.
- Serialises byte-wide message data into a bit stream for the constant-weight encoder datapath.
- Capacity is 32 bytes (256 bits).

Parameters:
- WR_WIDTH, 8, write word width in bits; fixed, not generic.
- WR_DEPTH, 32, capacity in write words.
- RD_DEPTH, 256, capacity in bits (WR_DEPTH*WR_WIDTH).
- WCNT_W, 6, width of wr_data_count; holds 0..32.
- RCNT_W, 9, width of rd_data_count; holds 0..256.

Ports:
- clk  in  1  single clock for both the write side and the read side.
- rst  in  1  reset; synchronous, active-high.
- din  in  8  write data byte.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  1  read data bit (registered).
- full  out  1  no free byte slot.
- empty  out  1  no unread bit.
- rd_data_count  out  9  unread bits, 0..256.
- wr_data_count  out  6  occupied byte slots, 0..32.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk; dominates all other inputs.
  - Effect of reset: storage pointers cleared, dout=0, empty=1, full=0, rd_data_count=0, wr_data_count=0.
  - Reset in the middle of a transfer discards all stored contents; the next cycle behaves as a fresh, empty FIFO.
- Storage: 32x8 array.
  - Write pointer: 5 bits plus a wrap bit.
  - Read pointer: 8-bit bit index (byte = idx[7:3], bit = idx[2:0]) plus a wrap bit.
- Write acceptance: a write is accepted when wr_en=1 and full=0. The byte is stored at the write slot and the write pointer increments, wrapping 31->0.
- Write to a full FIFO is ignored; contents, pointers and counts are unchanged.
- Read acceptance: a read is accepted when rd_en=1 and empty=0.
  - dout is registered with the selected bit on that edge, so it is valid 1 cycle after the accepted request (standard, non-FWFT mode).
  - Read pointer increments, wrapping 255->0.
- Bit order: bit index b within byte slot s maps to mem[s][7-b]. Byte din is therefore output as din[7], din[6], ..., din[0].
- Read from an empty FIFO is ignored; dout holds its previous value.
- Bit count: internal bitcnt, 0..256.
  - +8 on each accepted write, -1 on each accepted read.
  - Simultaneous accepted write and read gives +7.
  - Acceptance of each side is evaluated on pre-edge flags.
- Output derivations:
  - rd_data_count = bitcnt.
  - wr_data_count = ceil(bitcnt/8). A partially read byte still occupies its slot.
  - full = (wr_data_count==32).
  - empty = (bitcnt==0).
- Flag timing: all flags and counts are registered or derived from registered state, and update on the edge of the transfer.
  - A write into an empty FIFO deasserts empty from the next cycle.
  - The last-bit read asserts empty from the next cycle.
- Boundaries:
  - Reading the 8th bit of a slot frees that slot, which deasserts full on the next cycle.
  - Write while full with a simultaneous read is rejected, even if that read frees a slot.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined: two extra outputs, overflow and underflow, each 1 bit.
  - overflow is a registered 1-cycle pulse following a rejected write (wr_en with full).
  - underflow is a registered 1-cycle pulse following a rejected read (rd_en with empty).
  - Both outputs reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: WR_WIDTH, WR_DEPTH, RD_DEPTH, and the count widths as localparams.
- No typedefs are required.
- One natural sub-module: fifo_8to1_mem, the 32x8 array with a byte write port and a bit-select read port.
- Pointers, counts and flags stay in the top level.

Test Plan:
- Reset then idle: after rst=1 for 10 cycles, then release -> empty=1, full=0, both counts 0, dout=0.
- Write 30 bytes starting 0x40, 0x55 (no reads) -> rd_data_count=240, wr_data_count=30, full=0, empty=0.
- Then hold rd_en=1 -> dout sequence starts 0,1,0,0,0,0,0,0,0,1,0,1,0,1,0,1; rd_data_count decrements by 1 per cycle; empty=1 after 240 reads; dout then holds.
- Fill with 32 bytes -> full=1, wr_data_count=32, rd_data_count=256. A 33rd write is ignored: counts are unchanged, and overflow pulses when FIFO_ERR_FLAGS_EN is defined.
- From full, 1 read -> full stays 1, rd_data_count=255. After 8 reads -> full=0, wr_data_count=31.
- Simultaneous write and read on a non-full, non-empty FIFO -> rd_data_count +7. Pointer wrap across byte 31->0 preserves data order. Reset asserted mid-read -> empty=1 and counts 0 on the next cycle.

Source files
------------

// File: rtl/fifo_8to1_sync_pkg.sv
// Shared sizing for the 8-bit-in / 1-bit-out serialising FIFO.
package fifo_8to1_sync_pkg;

   localparam int WR_WIDTH = 8;
   localparam int WR_DEPTH = 32;
   localparam int RD_DEPTH = WR_DEPTH * WR_WIDTH;
   localparam int WCNT_W   = 6;
   localparam int RCNT_W   = 9;
   localparam int ADDR_W   = 5;
   localparam int BIT_W    = 3;
   localparam int WPTR_W   = ADDR_W + 1;
   localparam int RPTR_W   = ADDR_W + BIT_W + 1;

endpackage

// File: rtl/fifo_8to1_mem.sv
// 32x8 storage with a byte write port and an MSB-first bit-select read port.
module fifo_8to1_mem
   import fifo_8to1_sync_pkg::*;
(
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WR_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]   rd_byte,
   input  logic [BIT_W-1:0]    rd_bit,
   output logic                rd_data
);

   logic [WR_WIDTH-1:0] mem_q [WR_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // bit index 0 of a slot is the byte's MSB
   assign rd_data = mem_q[rd_byte][~rd_bit];

endmodule

// File: rtl/fifo_8to1_sync.sv
// Byte-in, bit-out synchronous FIFO (32 bytes / 256 bits), registered dout.
// Optional overflow/underflow pulse outputs when FIFO_ERR_FLAGS_EN is defined.
module fifo_8to1_sync
   import fifo_8to1_sync_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [WR_WIDTH-1:0] din,
   input  logic                wr_en,
   input  logic                rd_en,
   output logic                dout,
   output logic                full,
   output logic                empty,
   output logic [RCNT_W-1:0]   rd_data_count,
`ifdef FIFO_ERR_FLAGS_EN
   output logic [WCNT_W-1:0]   wr_data_count,
   output logic                overflow,
   output logic                underflow
`else
   output logic [WCNT_W-1:0]   wr_data_count
`endif
);

   logic [WPTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [RPTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              dout_q, dout_d;
   logic [RCNT_W-1:0] bitcnt;
   logic              wr_acc, rd_acc;
   logic              mem_bit;

   // Both pointers count in bits once the write pointer is scaled by 8; the
   // wrap bits make the modular difference span the full 0..256 range.
   assign bitcnt        = {wr_ptr_q, 3'b000} - rd_ptr_q;
   assign rd_data_count = bitcnt;
   assign wr_data_count = bitcnt[RCNT_W-1:BIT_W] + {{(WCNT_W-1){1'b0}}, |bitcnt[BIT_W-1:0]};
   assign full          = (wr_data_count == WCNT_W'(WR_DEPTH));
   assign empty         = (bitcnt == '0);
   assign dout          = dout_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   fifo_8to1_mem u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (din),
      .rd_byte (rd_ptr_q[ADDR_W+BIT_W-1:BIT_W]),
      .rd_bit  (rd_ptr_q[BIT_W-1:0]),
      .rd_data (mem_bit)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         dout_d   = mem_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = wr_en & full;
      underflow_d = rd_en & empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_8to1_sync.sv
// Directed bench for fifo_8to1_sync: bit-queue reference model plus a dout scoreboard.
module tb_fifo_8to1_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       wr_en;
   logic       rd_en;
   logic       dout;
   logic       full;
   logic       empty;
   logic [8:0] rd_data_count;
   logic [5:0] wr_data_count;
`ifdef FIFO_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   always #5 clk = ~clk;

   fifo_8to1_sync dut (
      .clk           (clk),
      .rst           (rst),
      .din           (din),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .dout          (dout),
      .full          (full),
      .empty         (empty),
      .rd_data_count (rd_data_count),
`ifdef FIFO_ERR_FLAGS_EN
      .wr_data_count (wr_data_count),
      .overflow      (overflow),
      .underflow     (underflow)
`else
      .wr_data_count (wr_data_count)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int   c;
      logic b;
   } exp_t;

   exp_t exp_q[$];
   bit   mq[$];
   logic last_bit = 1'b0;
   logic ovf_m    = 1'b0;
   logic unf_m    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // dout monitor: an entry becomes due on the edge index it was queued for
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
            e = exp_q.pop_front();
            chk("dout", {31'b0, dout}, {31'b0, e.b});
         end
      end
   end

   task automatic check_state();
      int n;
      n = mq.size();
      chk("empty", {31'b0, empty}, (n == 0) ? 32'd1 : 32'd0);
      chk("full", {31'b0, full}, (n > 248) ? 32'd1 : 32'd0);
      chk("rd_data_count", {23'b0, rd_data_count}, 32'(n));
      chk("wr_data_count", {26'b0, wr_data_count}, 32'((n + 7) / 8));
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
      chk("underflow", {31'b0, underflow}, {31'b0, unf_m});
`endif
   endtask

   // Called 1 time unit after a rising edge: check state, drive one cycle.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
      int   n;
      logic e_full, e_empty;
      check_state();
      wr_en = w;
      din   = d;
      rd_en = r;
      rst   = rs;
      n     = mq.size();
      if (rs) begin
         mq.delete();
         ovf_m    = 1'b0;
         unf_m    = 1'b0;
         last_bit = 1'b0;
         if (r) exp_q.push_back('{cyc + 1, 1'b0});
      end else begin
         e_full  = (n > 248);
         e_empty = (n == 0);
         ovf_m   = w && e_full;
         unf_m   = r && e_empty;
         if (r) begin
            if (!e_empty) last_bit = mq.pop_front();
            exp_q.push_back('{cyc + 1, last_bit});
         end
         if (w && !e_full) begin
            for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = 8'h00;
      repeat (10) @(posedge clk);
      #1;
      chk("reset_dout", {31'b0, dout}, 32'd0);

      step(1'b1, 8'h40, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      for (int i = 2; i < 30; i++) step(1'b1, 8'(i * 29), 1'b0, 1'b0);
      chk("fill30_rd_count", {23'b0, rd_data_count}, 32'd240);
      chk("fill30_wr_count", {26'b0, wr_data_count}, 32'd30);

      for (int i = 0; i < 245; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_empty", {31'b0, empty}, 32'd1);
      chk("drain_rd_count", {23'b0, rd_data_count}, 32'd0);

      for (int i = 0; i < 32; i++) step(1'b1, 8'hC3 ^ 8'(i), 1'b0, 1'b0);
      chk("fill32_full", {31'b0, full}, 32'd1);
      chk("fill32_wr_count", {26'b0, wr_data_count}, 32'd32);
      chk("fill32_rd_count", {23'b0, rd_data_count}, 32'd256);

      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_rd_count", {23'b0, rd_data_count}, 32'd256);

      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("full_wr_rd_count", {23'b0, rd_data_count}, 32'd255);
      chk("full_wr_rd_full", {31'b0, full}, 32'd1);

      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("slot_free_full", {31'b0, full}, 32'd0);
      chk("slot_free_wr_count", {26'b0, wr_data_count}, 32'd31);

      step(1'b1, 8'h3C, 1'b1, 1'b0);
      chk("simul_rd_count", {23'b0, rd_data_count}, 32'd255);

      for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("midreset_empty", {31'b0, empty}, 32'd1);
      chk("midreset_rd_count", {23'b0, rd_data_count}, 32'd0);
      chk("midreset_wr_count", {26'b0, wr_data_count}, 32'd0);

      step(1'b1, 8'h81, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
      check_state();

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
